// File: rtl/bzled_pattern_seq_if.sv
// Host-side bus of the BZLED pattern sequencer: slot writes, playback control
// and the PWM settings handed on to perip_BZLED.
interface bzled_pattern_seq_if #(
    parameter int SLOTS = 8
);
    localparam int SW = $clog2(SLOTS);

    logic          wr_en;
    logic [SW+2:0] wr_addr;
    logic [31:0]   wr_data;
    logic          start;
    logic          stop;
    logic [SW:0]   num_slots;
    logic          loop_en;

    logic [31:0]   LED_FREQ_Set;
    logic [31:0]   BZ_FREQ_Set;
    logic [31:0]   LEDR_Puty_Set;
    logic [31:0]   LEDG_Puty_Set;
    logic [31:0]   LEDB_Puty_Set;
    logic          busy;
    logic [SW-1:0] slot_idx;
    logic          done;

    modport master (
        output wr_en, wr_addr, wr_data, start, stop, num_slots, loop_en,
        input  LED_FREQ_Set, BZ_FREQ_Set, LEDR_Puty_Set, LEDG_Puty_Set,
               LEDB_Puty_Set, busy, slot_idx, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, stop, num_slots, loop_en,
        output LED_FREQ_Set, BZ_FREQ_Set, LEDR_Puty_Set, LEDG_Puty_Set,
               LEDB_Puty_Set, busy, slot_idx, done
    );
endinterface

// File: rtl/bzled_pattern_seq.sv
// Plays host-loaded LED/buzzer pattern slots onto the perip_BZLED settings,
// holding each slot for its dwell time, then stopping or looping.
module bzled_pattern_seq #(
    parameter int SLOTS    = 8,
    parameter int TICK_DIV = 50000
) (
    input  logic               CLK,
    input  logic               RST_n,
    bzled_pattern_seq_if.slave io_bus
);
    localparam int SW = $clog2(SLOTS);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_TC = PW'(TICK_DIV - 1);

    // state | meaning
    // IDLE  | outputs zero, waiting for start
    // PLAY  | a slot is on the outputs, dwell timers running
    typedef enum logic {IDLE, PLAY} state_t;

    state_t r_state, w_state_nxt;

    logic [31:0] r_led_freq [SLOTS];
    logic [31:0] r_bz_freq  [SLOTS];
    logic [31:0] r_ledr     [SLOTS];
    logic [31:0] r_ledg     [SLOTS];
    logic [31:0] r_ledb     [SLOTS];
    logic [15:0] r_dwell    [SLOTS];

    logic [31:0]   r_led_set, r_bz_set, r_r_set, r_g_set, r_b_set;
    logic [SW-1:0] r_slot_idx;
    logic [SW-1:0] r_last_idx;
    logic [PW-1:0] r_pre;
    logic [15:0]   r_dwell_cnt;
    logic          r_done;

    logic          w_load, w_clear, w_done, w_latch, w_slot_end;
    logic [SW-1:0] w_load_idx, w_last_idx, w_wr_slot;
    logic [2:0]    w_field;
    logic [15:0]   w_dwell_sel, w_dwell_init;

    assign w_field      = io_bus.wr_addr[2:0];
    assign w_wr_slot    = io_bus.wr_addr[SW+2:3];
    assign w_slot_end   = (r_state == PLAY) && (r_pre == '0) && (r_dwell_cnt == 16'd0);
    assign w_dwell_sel  = r_dwell[w_load_idx];
    assign w_dwell_init = (w_dwell_sel == 16'd0) ? 16'd0 : w_dwell_sel - 16'd1;

    always_comb begin
        if (io_bus.num_slots == '0)
            w_last_idx = '0;
        else if (io_bus.num_slots > (SW+1)'(SLOTS))
            w_last_idx = SW'(SLOTS - 1);
        else
            w_last_idx = SW'(io_bus.num_slots - (SW+1)'(1));
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // stop beats start, start beats the natural slot boundary
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_idx  = '0;
        w_clear     = 1'b0;
        w_done      = 1'b0;
        w_latch     = 1'b0;
        if (io_bus.stop) begin
            w_state_nxt = IDLE;
            w_clear     = 1'b1;
        end else if (io_bus.start) begin
            w_state_nxt = PLAY;
            w_load      = 1'b1;
            w_latch     = 1'b1;
        end else if (w_slot_end) begin
            if (r_slot_idx != r_last_idx) begin
                w_load     = 1'b1;
                w_load_idx = r_slot_idx + SW'(1);
            end else if (io_bus.loop_en) begin
                w_load = 1'b1;
            end else begin
                w_state_nxt = IDLE;
                w_clear     = 1'b1;
                w_done      = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            for (int i = 0; i < SLOTS; i++) begin
                r_led_freq[i] <= '0;
                r_bz_freq[i]  <= '0;
                r_ledr[i]     <= '0;
                r_ledg[i]     <= '0;
                r_ledb[i]     <= '0;
                r_dwell[i]    <= '0;
            end
        end else if (io_bus.wr_en) begin
            case (w_field)
                3'd0:    r_led_freq[w_wr_slot] <= io_bus.wr_data;
                3'd1:    r_bz_freq[w_wr_slot]  <= io_bus.wr_data;
                3'd2:    r_ledr[w_wr_slot]     <= io_bus.wr_data;
                3'd3:    r_ledg[w_wr_slot]     <= io_bus.wr_data;
                3'd4:    r_ledb[w_wr_slot]     <= io_bus.wr_data;
                3'd5:    r_dwell[w_wr_slot]    <= io_bus.wr_data[15:0];
                default: ;
            endcase
        end
    end

    // Slot loads read storage before this edge's write lands, so a colliding
    // write only shows up on the next load of that slot.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_led_set   <= '0;
            r_bz_set    <= '0;
            r_r_set     <= '0;
            r_g_set     <= '0;
            r_b_set     <= '0;
            r_slot_idx  <= '0;
            r_last_idx  <= '0;
            r_pre       <= '0;
            r_dwell_cnt <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_done;
            if (w_latch) r_last_idx <= w_last_idx;
            if (w_clear) begin
                r_led_set   <= '0;
                r_bz_set    <= '0;
                r_r_set     <= '0;
                r_g_set     <= '0;
                r_b_set     <= '0;
                r_slot_idx  <= '0;
                r_pre       <= '0;
                r_dwell_cnt <= '0;
            end else if (w_load) begin
                r_led_set   <= r_led_freq[w_load_idx];
                r_bz_set    <= r_bz_freq[w_load_idx];
                r_r_set     <= r_ledr[w_load_idx];
                r_g_set     <= r_ledg[w_load_idx];
                r_b_set     <= r_ledb[w_load_idx];
                r_slot_idx  <= w_load_idx;
                r_pre       <= PRE_TC;
                r_dwell_cnt <= w_dwell_init;
            end else if (r_state == PLAY) begin
                if (r_pre == '0) begin
                    r_pre       <= PRE_TC;
                    r_dwell_cnt <= r_dwell_cnt - 16'd1;
                end else begin
                    r_pre <= r_pre - PW'(1);
                end
            end
        end
    end

    assign io_bus.LED_FREQ_Set  = r_led_set;
    assign io_bus.BZ_FREQ_Set   = r_bz_set;
    assign io_bus.LEDR_Puty_Set = r_r_set;
    assign io_bus.LEDG_Puty_Set = r_g_set;
    assign io_bus.LEDB_Puty_Set = r_b_set;
    assign io_bus.busy          = (r_state == PLAY);
    assign io_bus.slot_idx      = r_slot_idx;
    assign io_bus.done          = r_done;
endmodule

// File: tb/tb_bzled_pattern_seq.sv
// Bench for bzled_pattern_seq: a cycle model queues the expected output
// snapshot each edge, a monitor compares the DUT against it, plus directed counts.
`timescale 1ns/1ps
module tb_bzled_pattern_seq;
    localparam int SLOTS    = 8;
    localparam int TICK_DIV = 4;
    localparam int SW       = 3;

    typedef logic [164:0] snap_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bzled_pattern_seq_if #(.SLOTS(SLOTS)) bus ();

    bzled_pattern_seq #(.SLOTS(SLOTS), .TICK_DIV(TICK_DIV)) dut (
        .CLK    (clk),
        .RST_n  (rst_n),
        .io_bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int busy_cyc = 0;
    snap_t sb_q[$];

    task automatic check_eq(input string tag, input snap_t got, input snap_t exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // reference model: elapsed-cycle count per slot against dwell*TICK_DIV
    logic [31:0] m_mem [SLOTS][6];
    logic [31:0] m_out [5];
    bit m_play, m_done;
    int m_idx, m_cnt, m_elapsed, m_len;

    task automatic model_idle();
        m_play = 0; m_idx = 0; m_elapsed = 0; m_len = 1;
        for (int f = 0; f < 5; f++) m_out[f] = '0;
    endtask

    task automatic model_load(input int i);
        logic [15:0] d;
        m_idx = i;
        for (int f = 0; f < 5; f++) m_out[f] = m_mem[i][f];
        d = m_mem[i][5][15:0];
        m_len = ((d == 16'd0) ? 1 : int'(d)) * TICK_DIV;
        m_elapsed = 0;
        m_play = 1;
    endtask

    task automatic model_step();
        int n;
        m_done = 0;
        if (!rst_n) begin
            model_idle();
            m_cnt = 1;
            for (int s = 0; s < SLOTS; s++)
                for (int f = 0; f < 6; f++) m_mem[s][f] = '0;
        end else begin
            if (bus.stop) begin
                model_idle();
            end else if (bus.start) begin
                n = int'(bus.num_slots);
                m_cnt = (n == 0) ? 1 : ((n > SLOTS) ? SLOTS : n);
                model_load(0);
            end else if (m_play) begin
                m_elapsed++;
                if (m_elapsed >= m_len) begin
                    if (m_idx + 1 < m_cnt) model_load(m_idx + 1);
                    else if (bus.loop_en) model_load(0);
                    else begin
                        model_idle();
                        m_done = 1;
                    end
                end
            end
            if (bus.wr_en && bus.wr_addr[2:0] < 3'd6)
                m_mem[bus.wr_addr[SW+2:3]][bus.wr_addr[2:0]] = bus.wr_data;
        end
        sb_q.push_back({m_out[0], m_out[1], m_out[2], m_out[3], m_out[4],
                        m_play, 3'(m_idx), m_done});
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(posedge clk);
        #2;
        cyc++;
        if (bus.done) done_cnt++;
        if (bus.busy) busy_cyc++;
        if (sb_q.size() == 0)
            check_eq("sb_empty", snap_t'(0), snap_t'(1));
        else
            check_eq($sformatf("cyc%0d", cyc),
                     {bus.LED_FREQ_Set, bus.BZ_FREQ_Set, bus.LEDR_Puty_Set,
                      bus.LEDG_Puty_Set, bus.LEDB_Puty_Set, bus.busy,
                      bus.slot_idx, bus.done},
                     sb_q.pop_front());
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input int slot, input int field, input logic [31:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = {3'(slot), 3'(field)};
        bus.wr_data = data;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic write_slot(input int s, input logic [31:0] led, input logic [31:0] bz,
                              input logic [31:0] r, input logic [31:0] g,
                              input logic [31:0] b, input logic [31:0] dw);
        wr(s, 0, led); wr(s, 1, bz); wr(s, 2, r);
        wr(s, 3, g);   wr(s, 4, b);  wr(s, 5, dw);
    endtask

    task automatic pulse_start(input int n);
        bus.num_slots = 4'(n);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        while (bus.busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (bus.busy) check_eq({tag, "_timeout"}, snap_t'(1), snap_t'(0));
    endtask

    task automatic wait_idx(input string tag, input int idx, input int budget);
        int k = 0;
        while (!(m_play && m_idx == idx) && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (!(m_play && m_idx == idx)) check_eq({tag, "_timeout"}, snap_t'(0), snap_t'(1));
    endtask

    int d0, b0;

    initial begin
        bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.start = 0; bus.stop = 0; bus.num_slots = '0; bus.loop_en = 0;
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // reset mid-playback aborts with no done pulse and clears storage
        write_slot(0, 32'd10000, 32'd10000, 32'd1000, 32'd1000, 32'd1000, 32'd1);
        pulse_start(1);
        tick(1);
        d0 = done_cnt;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(8);
        check_eq("rst_no_done", snap_t'(done_cnt - d0), snap_t'(0));
        write_slot(0, 32'd10000, 32'd10000, 32'd1000, 32'd1000, 32'd1000, 32'd1);
        tick(2);
        check_eq("idle_out_zero", snap_t'(bus.LED_FREQ_Set), snap_t'(0));

        // single pass, dwell 1,2,3
        write_slot(1, 32'd2001, 32'd2002, 32'd2003, 32'd2004, 32'd2005, 32'd2);
        write_slot(2, 32'd3001, 32'd3002, 32'd3003, 32'd3004, 32'd3005, 32'd3);
        d0 = done_cnt; busy_cyc = 0;
        pulse_start(3);
        wait_idle("pass", 100);
        tick(2);
        check_eq("pass_busy_cycles", snap_t'(busy_cyc), snap_t'(24));
        check_eq("pass_done", snap_t'(done_cnt - d0), snap_t'(1));

        // loop with live writes, then release loop_en in pass 3
        d0 = done_cnt;
        bus.loop_en = 1'b1;
        pulse_start(2);
        wait_idx("loop_s1", 1, 50);
        wr(1, 2, 32'd500);
        begin : coincide
            int k = 0;
            while (!(m_play && m_idx == 1 && m_elapsed == m_len - 1) && k < 50) begin
                @(negedge clk);
                k++;
            end
            if (k >= 50) check_eq("coincide_timeout", snap_t'(0), snap_t'(1));
        end
        wr(0, 3, 32'd777);
        wait_idx("loop_p2s1", 1, 50);
        wait_idx("loop_p3s0", 0, 50);
        bus.loop_en = 1'b0;
        wait_idle("loop", 100);
        tick(2);
        check_eq("loop_done_once", snap_t'(done_cnt - d0), snap_t'(1));

        // dwell 0 lasts one tick; num_slots 0 plays slot 0 only
        wr(0, 5, 32'd0);
        d0 = done_cnt; busy_cyc = 0;
        pulse_start(0);
        wait_idle("n0", 50);
        tick(2);
        check_eq("dwell0_cycles", snap_t'(busy_cyc), snap_t'(TICK_DIV));
        check_eq("n0_done", snap_t'(done_cnt - d0), snap_t'(1));

        // num_slots beyond SLOTS clamps
        for (int s = 0; s < SLOTS; s++) begin
            wr(s, 0, 32'(100 + s));
            wr(s, 5, 32'd1);
        end
        busy_cyc = 0;
        pulse_start(SLOTS + 3);
        wait_idle("clamp", 200);
        tick(2);
        check_eq("clamp_cycles", snap_t'(busy_cyc), snap_t'(SLOTS * TICK_DIV));

        // stop during slot 1
        wr(1, 5, 32'd2); wr(2, 5, 32'd3);
        d0 = done_cnt;
        pulse_start(3);
        wait_idx("stop_s1", 1, 50);
        tick(1);
        pulse_stop();
        check_eq("stop_busy", snap_t'(bus.busy), snap_t'(0));
        tick(4);
        check_eq("stop_no_done", snap_t'(done_cnt - d0), snap_t'(0));

        // start and stop together in IDLE
        bus.num_slots = 4'd3;
        bus.start = 1'b1; bus.stop = 1'b1;
        tick(1);
        bus.start = 1'b0; bus.stop = 1'b0;
        tick(2);
        check_eq("startstop_idle", snap_t'(bus.busy), snap_t'(0));

        // restart during slot 2
        d0 = done_cnt;
        pulse_start(3);
        wait_idx("rs_s2", 2, 50);
        tick(3);
        pulse_start(3);
        check_eq("restart_idx", snap_t'(bus.slot_idx), snap_t'(0));
        wait_idle("restart", 100);
        tick(2);
        check_eq("restart_done", snap_t'(done_cnt - d0), snap_t'(1));

        tick(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
